cache_mem_ctrl: RTL
===================

CACHE_MEM_CTRL -- requirements
Module: cache_mem_ctrl

Interface
REQ-001 Parameter PA_WIDTH, default 32, physical address width.
REQ-002 Parameter WRD_WIDTH, default 32, memory bus word width.
REQ-003 Parameter BLK_WIDTH, default 512, cache block width; WPB = BLK_WIDTH/WRD_WIDTH = 16 words per block.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 cache_rd_en  in  1  block refill request.
REQ-008 cache_wr_en  in  1  block writeback request.
REQ-009 cache_addr  in  PA_WIDTH  block address; low 6 bits ignored.
REQ-010 cache_wr_blk  in  BLK_WIDTH  block to write back; word k in bits [32k+31:32k].
REQ-011 cache_rd_blk  out  BLK_WIDTH  assembled refill block.
REQ-012 cache_done  out  1  one-cycle completion pulse.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 bus_valid  out  1  beat request valid.
REQ-015 bus_we  out  1  1 = write beat, 0 = read beat.
REQ-016 bus_addr  out  PA_WIDTH  beat word address.
REQ-017 bus_wdata  out  WRD_WIDTH  write beat data.
REQ-018 bus_ready  in  1  memory accepts beat when bus_valid && bus_ready.
REQ-019 bus_rdata  in  WRD_WIDTH  read return data.
REQ-020 bus_rvalid  in  1  bus_rdata valid; returns in request order.

Function
REQ-021 States: IDLE, WR, RD, DONE.
REQ-022 IDLE: on cache_wr_en -> WR; else on cache_rd_en -> RD; cache_addr and cache_wr_blk captured at that edge; later input changes ignored.
REQ-023 Both enables high in IDLE: write wins; read dropped, cache must reissue it.
REQ-024 Requests arriving outside IDLE are ignored (no queueing).
REQ-025 Beat address = {captured addr[PA_WIDTH-1:6], beat[3:0], 2'b00}.
REQ-026 WR: bus_valid=1, bus_we=1, bus_wdata = captured word[beat]; beat counter increments on each accepted beat; after beat 15 accepted -> DONE.
REQ-027 RD: issue counter drives read beats 0..15 (bus_valid=1, bus_we=0) until 16 accepted, then bus_valid=0; return counter writes bus_rdata into word[rcnt] of cache_rd_blk on each bus_rvalid; issue and return overlap.
REQ-028 RD -> DONE on the cycle the 16th bus_rvalid is captured; bus_rvalid in IDLE, WR or DONE ignored.
REQ-029 bus_valid held with stable bus_addr/bus_wdata while bus_ready=0.
REQ-030 DONE: cache_done=1 for exactly one cycle, bus_valid=0, then -> IDLE unconditionally.
REQ-031 cache_rd_blk changes only during RD and holds its value through and after DONE until the next refill.
REQ-032 Counters are 4 bits and wrap 15->0; never exceed 16 beats per request.
REQ-033 Latency with bus_ready=1, rvalid one cycle after accept: write accepted cycle 0, beats cycles 1-16, cache_done cycle 17; read cache_done cycle 18.

Reset
REQ-034 rst_n low, asynchronously, at any point including mid-burst: state=IDLE, counters=0, bus_valid=0, bus_we=0, bus_addr=0, bus_wdata=0, cache_rd_blk=0, cache_done=0, busy=0.
REQ-035 A burst interrupted by reset is abandoned; no completion pulse follows.

Verification
REQ-036 Write, addr=0x0000_1040, blk words k=0xA000_000k, bus_ready=1 -> 16 beats addr 0x1040..0x107C, data 0xA0000000..0xA000000F, cache_done cycle 17.
REQ-037 Read, addr=0x2000, memory returns 0xB000_000k one cycle after accept -> cache_rd_blk word k=0xB000000k, cache_done cycle 18, busy low after.
REQ-038 Write with bus_ready toggling 1/0 each cycle -> bus_addr/bus_wdata stable while stalled, exactly 16 accepted beats, single cache_done.
REQ-039 cache_rd_en and cache_wr_en both high in IDLE -> only write burst, one cache_done, no read beats.
REQ-040 rst_n pulsed low after beat 7 of a read -> outputs at reset values immediately, no cache_done; new read afterwards completes normally.
REQ-041 cache_rd_en asserted during WR and during DONE -> ignored; bus returns idle after DONE.

Source files
------------

// File: rtl/cache_mem_ctrl.sv
// cache_mem_ctrl
//   Moves one cache block between the cache and a word-wide memory bus.
//   A writeback streams the captured block out as WPB write beats. A refill
//   issues WPB read beats and assembles the returned words into cache_rd_blk.
//   Read issue and read return run concurrently. Returns arrive in request order.
//
// Ports
//   clk, rst_n      clock and asynchronous active-low reset
//   cache_rd_en     refill request, sampled in IDLE only
//   cache_wr_en     writeback request, sampled in IDLE only; wins over refill
//   cache_addr      block address, low offset bits ignored
//   cache_wr_blk    block to write back, word k in bits [k*WRD_WIDTH +: WRD_WIDTH]
//   cache_rd_blk    assembled refill block, held until the next refill
//   cache_done      one-cycle completion pulse
//   busy            high whenever the controller is not idle
//   bus_valid/bus_we/bus_addr/bus_wdata   beat request toward memory
//   bus_ready       memory accepts the beat when bus_valid && bus_ready
//   bus_rdata/bus_rvalid                  read return from memory
module cache_mem_ctrl #(
  parameter int unsigned PA_WIDTH  = 32,
  parameter int unsigned WRD_WIDTH = 32,
  parameter int unsigned BLK_WIDTH = 512
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cache_rd_en,
  input  logic                 cache_wr_en,
  input  logic [PA_WIDTH-1:0]  cache_addr,
  input  logic [BLK_WIDTH-1:0] cache_wr_blk,
  output logic [BLK_WIDTH-1:0] cache_rd_blk,
  output logic                 cache_done,
  output logic                 busy,
  output logic                 bus_valid,
  output logic                 bus_we,
  output logic [PA_WIDTH-1:0]  bus_addr,
  output logic [WRD_WIDTH-1:0] bus_wdata,
  input  logic                 bus_ready,
  input  logic [WRD_WIDTH-1:0] bus_rdata,
  input  logic                 bus_rvalid
);

  localparam int unsigned WPB = BLK_WIDTH / WRD_WIDTH;
  localparam int unsigned CW  = $clog2(WPB);
  localparam int unsigned OFS = $clog2(WRD_WIDTH / 8);
  localparam int unsigned LSB = CW + OFS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [PA_WIDTH-1:LSB]            addr_q;
  logic [WPB-1:0][WRD_WIDTH-1:0]    wblk_q;
  logic [WPB-1:0][WRD_WIDTH-1:0]    rblk_q;
  logic [CW-1:0]                    icnt;
  logic [CW-1:0]                    rcnt;
  logic                             issued_all;
  logic                             beat_acc;
  logic                             unused_addr_bits;

  assign unused_addr_bits = ^cache_addr[LSB-1:0];
  assign cache_rd_blk     = rblk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    bus_valid  = 1'b0;
    bus_we     = 1'b0;
    bus_wdata  = '0;
    bus_addr   = {addr_q, icnt, {OFS{1'b0}}};
    cache_done = 1'b0;
    busy       = 1'b1;

    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (cache_wr_en) begin
          state_nxt = WR;
        end else if (cache_rd_en) begin
          state_nxt = RD;
        end
      end
      WR: begin
        bus_valid = 1'b1;
        bus_we    = 1'b1;
        bus_wdata = wblk_q[icnt];
        if (bus_ready && (icnt == '1)) begin
          state_nxt = DONE;
        end
      end
      RD: begin
        bus_valid = !issued_all;
        // Completion follows the last return, not the last issue.
        if (bus_rvalid && (rcnt == '1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        cache_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    beat_acc = bus_valid && bus_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      wblk_q     <= '0;
      rblk_q     <= '0;
      icnt       <= '0;
      rcnt       <= '0;
      issued_all <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          icnt       <= '0;
          rcnt       <= '0;
          issued_all <= 1'b0;
          if (cache_wr_en) begin
            addr_q <= cache_addr[PA_WIDTH-1:LSB];
            wblk_q <= cache_wr_blk;
          end else if (cache_rd_en) begin
            addr_q <= cache_addr[PA_WIDTH-1:LSB];
          end
        end
        WR: begin
          if (beat_acc) begin
            icnt <= icnt + 1'b1;
          end
        end
        RD: begin
          if (beat_acc) begin
            icnt <= icnt + 1'b1;
            if (icnt == '1) begin
              issued_all <= 1'b1;
            end
          end
          if (bus_rvalid) begin
            rblk_q[rcnt] <= bus_rdata;
            rcnt         <= rcnt + 1'b1;
          end
        end
        DONE: begin
          icnt <= '0;
          rcnt <= '0;
        end
        default: begin
          icnt <= '0;
        end
      endcase
    end
  end

endmodule
